fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   LC-3b pipeline FETCH stage: holds the architectural PC and fetches from the instruction
//   cache over a req/ready handshake. Loads the DE latches (de_npc, de_ir, de_v) read by
//   the decode stage. Honours decode/mem stalls and branch stalls, and takes PC redirects
//   resolved in the MEM stage.
// PARAMETERS
//   RESET_PC  16'h3000  PC value loaded on reset
// PORTS
//   clk              in   1   system clock, all state updates on posedge
//   reset            in   1   synchronous, active-high reset
//   icache_req       out  1   fetch request, high in state FETCH only
//   icache_addr      out  16  fetch address (= pc), stable while icache_req=1
//   icache_ready     in   1   icache_data valid this cycle for icache_addr
//   icache_data      in   16  instruction word
//   dep_stall        in   1   decode dependency stall
//   mem_stall        in   1   MEM stage dcache stall
//   v_de_br_stall    in   1   control instr valid in DE
//   v_agex_br_stall  in   1   control instr valid in AGEX
//   v_mem_br_stall   in   1   control instr valid in MEM
//   mem_pcmux        in   2   0:no redirect 1:target_pc 2:trap_pc 3:reserved(=0)
//   target_pc        in   16  branch/JSR/JMP target from MEM
//   trap_pc          in   16  trap vector target from MEM
//   de_npc           out  16  DE.NPC latch
//   de_ir            out  16  DE.IR latch
//   de_v             out  1   DE.V latch
//   pc               out  16  architectural PC (debug/trace)
// BEHAVIOUR
//   Reset: pc=RESET_PC; de_npc=0; de_ir=0; de_v=0; state=IDLE (icache_req=0). Reset beats all.
//   FSM (2 states): IDLE -> FETCH unconditionally next cycle.
//     FETCH -> IDLE on redirect (drops in-flight access). Otherwise FETCH holds.
//     icache_req = (state==FETCH); icache_addr = pc.
//   Derived signals:
//     hit      = FETCH & icache_ready
//     br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall
//     ld_de    = ~(dep_stall | mem_stall)
//     redirect = mem_pcmux==1 | mem_pcmux==2
//   PC: if redirect, pc <= (mem_pcmux==1 ? target_pc : trap_pc). Applies even if
//     ld_de=0 or br_stall=1.
//     Else if hit & ld_de & ~br_stall, pc <= pc+2 (16-bit, FFFE wraps to 0000).
//     Else pc holds.
//   DE latches: load only when ld_de=1, otherwise all three hold.
//     de_ir <= icache_data; de_npc <= pc+2 (wrapping).
//     de_v  <= hit & ~br_stall & ~redirect.
//   Latency: instruction at pc reaches de_ir one cycle after the hit cycle.
//     Back-to-back hits give one instruction per cycle.
//   Hit while stalled (ld_de=0 or br_stall): data discarded. Stay in FETCH, same address,
//     re-read next cycle (icache reads are idempotent).
//   icache_ready low: icache_req and addr held; de_v loads 0 when ld_de=1.
//   Redirect + hit same cycle: fetched word dropped. de_v loads 0 if ld_de.
//     One IDLE cycle, then fetch at new pc.
//   Reset asserted mid-fetch: request dropped next cycle; icache must tolerate abandonment.
// TESTING
//   1 Reset 2 cyc, ready=1, no stalls -> req from cyc 1; icache_addr 3000,3002,3004;
//     de_npc 3002,3004; de_v=1 from cyc 2.
//   2 ready=0 for 3 cycles at pc=3004 -> addr held 3004, de_v=0 those cycles, pc=3004;
//     ready=1 -> de_ir=data, pc=3006.
//   3 dep_stall=1 for 2 cycles -> de_ir/de_npc/de_v hold; pc holds; resume refetches same addr.
//   4 v_de_br_stall=1 with hits -> de_v=0, pc holds until mem_pcmux=1, target_pc=4000
//     -> pc=4000, 1 IDLE cycle, next req addr 4000.
//   5 mem_pcmux=2, trap_pc=0400 with mem_stall=1 -> pc=0400, DE latches unchanged.
//     mem_pcmux=3 -> no redirect.
//   6 pc=FFFE, hit -> pc=0000, de_npc=0000; reset mid-wait -> pc=3000, de_v=0, req=0.

Source files
------------

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the architectural PC, fetches from the icache, loads the DE latches.
// Latency: an instruction hit at pc appears in de_ir one cycle later; back-to-back hits stream at one per cycle.
// Backpressure: dep/mem stalls freeze the DE latches, and branch stalls freeze the PC; stalled hits are dropped and re-read.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h3000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        icache_req,
   output logic [15:0] icache_addr,
   input  logic        icache_ready,
   input  logic [15:0] icache_data,
   input  logic        dep_stall,
   input  logic        mem_stall,
   input  logic        v_de_br_stall,
   input  logic        v_agex_br_stall,
   input  logic        v_mem_br_stall,
   input  logic [1:0]  mem_pcmux,
   input  logic [15:0] target_pc,
   input  logic [15:0] trap_pc,
   output logic [15:0] de_npc,
   output logic [15:0] de_ir,
   output logic        de_v,
   output logic [15:0] pc
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   // mem_pcmux encodings; the fourth code is reserved and behaves as no redirect
   localparam logic [1:0] PCMUX_NONE   = 2'd0;
   localparam logic [1:0] PCMUX_TARGET = 2'd1;
   localparam logic [1:0] PCMUX_TRAP   = 2'd2;

   state_t      state;
   state_t      state_nxt;

   logic        in_fetch;
   logic        hit;
   logic        br_stall;
   logic        ld_de;
   logic        redirect;
   logic        advance;
   logic [15:0] pc_inc;
   logic [15:0] redirect_pc;
   logic [15:0] pc_nxt;
   logic        de_v_nxt;

   // Derived control terms shared by the PC and DE latch updates
   always_comb begin
      in_fetch    = (state == FETCH);
      hit         = in_fetch & icache_ready;
      br_stall    = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
      ld_de       = ~(dep_stall | mem_stall);
      redirect    = (mem_pcmux == PCMUX_TARGET) | (mem_pcmux == PCMUX_TRAP);
      // A hit only consumes the word when decode can take it and no control instr is in flight
      advance     = hit & ld_de & ~br_stall;
      // 16-bit add wraps FFFE to 0000 naturally
      pc_inc      = pc + 16'd2;
      redirect_pc = (mem_pcmux == PCMUX_TARGET) ? target_pc : trap_pc;
      // Word is valid for decode only if it was really fetched and not squashed
      de_v_nxt    = hit & ~br_stall & ~redirect;
   end

   // Next PC: a MEM redirect wins over everything, including stalls
   always_comb begin
      pc_nxt = pc;
      if (redirect) begin
         pc_nxt = redirect_pc;
      end else if (advance) begin
         pc_nxt = pc_inc;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: a redirect abandons the in-flight access for one idle cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   state_nxt = redirect ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request only while fetching; the address is always the PC so it is stable while held
   always_comb begin
      icache_req  = in_fetch;
      icache_addr = pc;
   end

   // Architectural PC register
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_nxt;
      end
   end

   // DE latches: all three load together when decode is not stalled, otherwise hold
   always_ff @(posedge clk) begin
      if (reset) begin
         de_npc <= 16'h0000;
         de_ir  <= 16'h0000;
         de_v   <= 1'b0;
      end else if (ld_de) begin
         de_npc <= pc_inc;
         de_ir  <= icache_data;
         de_v   <= de_v_nxt;
      end
   end

   // PCMUX_NONE is kept for readability of the encoding table only
   logic unused_ok;
   always_comb begin
      unused_ok = (PCMUX_NONE == 2'd0);
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then random traffic.
// Every cycle the DUT outputs are compared against a transaction-level model of the fetch rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        icache_req;
   logic [15:0] icache_addr;
   logic        icache_ready;
   logic [15:0] icache_data;
   logic        dep_stall;
   logic        mem_stall;
   logic        v_de_br_stall;
   logic        v_agex_br_stall;
   logic        v_mem_br_stall;
   logic [1:0]  mem_pcmux;
   logic [15:0] target_pc;
   logic [15:0] trap_pc;
   logic [15:0] de_npc;
   logic [15:0] de_ir;
   logic        de_v;
   logic [15:0] pc;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: what the outputs must be after the last rising edge
   logic [15:0] m_pc;
   bit          m_busy;   // a fetch request is outstanding
   logic [15:0] m_npc;
   logic [15:0] m_ir;
   bit          m_v;

   fetch_stage #(.RESET_PC(16'h3000)) dut (
      .clk(clk), .reset(reset),
      .icache_req(icache_req), .icache_addr(icache_addr),
      .icache_ready(icache_ready), .icache_data(icache_data),
      .dep_stall(dep_stall), .mem_stall(mem_stall),
      .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
      .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
      .target_pc(target_pc), .trap_pc(trap_pc),
      .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v), .pc(pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // advance the model by one clock using the currently driven inputs
   task automatic model_tick();
      bit          got_word;
      bit          any_br;
      bit          dec_free;
      bit          jump;
      logic [15:0] seq_pc;
      if (reset) begin
         m_pc = 16'h3000; m_busy = 0; m_npc = 0; m_ir = 0; m_v = 0;
         return;
      end
      got_word = m_busy && icache_ready;
      any_br   = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
      dec_free = !dep_stall && !mem_stall;
      jump     = (mem_pcmux == 2'd1) || (mem_pcmux == 2'd2);
      seq_pc   = m_pc + 16'd2;
      if (dec_free) begin
         m_ir  = icache_data;
         m_npc = seq_pc;
         m_v   = got_word && !any_br && !jump;
      end
      if (jump)                                m_pc = (mem_pcmux == 2'd1) ? target_pc : trap_pc;
      else if (got_word && dec_free && !any_br) m_pc = seq_pc;
      m_busy = m_busy ? !jump : 1'b1;
   endtask

   // one clock: model and DUT advance together, then every output is compared
   task automatic step();
      model_tick();
      @(posedge clk);
      @(negedge clk);
      chk("req",  {15'd0, icache_req}, {15'd0, m_busy});
      chk("addr", icache_addr, m_pc);
      chk("pc",   pc, m_pc);
      chk("de_v", {15'd0, de_v}, {15'd0, m_v});
      chk("de_ir", de_ir, m_ir);
      chk("de_npc", de_npc, m_npc);
   endtask

   task automatic idle_inputs();
      dep_stall = 0; mem_stall = 0;
      v_de_br_stall = 0; v_agex_br_stall = 0; v_mem_br_stall = 0;
      mem_pcmux = 0; target_pc = 16'h0; trap_pc = 16'h0;
   endtask

   initial begin
      logic [15:0] hold_ir;
      logic [15:0] hold_npc;
      logic        hold_v;
      reset = 1; icache_ready = 1; icache_data = 16'h0;
      idle_inputs();
      m_pc = 16'h3000; m_busy = 0; m_npc = 0; m_ir = 0; m_v = 0;

      // 1: reset then streaming hits
      step(); step();
      chk("rst_pc", pc, 16'h3000);
      chk("rst_req", {15'd0, icache_req}, 16'd0);
      chk("rst_de_v", {15'd0, de_v}, 16'd0);
      reset = 0; icache_data = memf(m_pc);
      step();
      chk("t1_req", {15'd0, icache_req}, 16'd1);
      chk("t1_addr0", icache_addr, 16'h3000);
      icache_data = memf(m_pc); step();
      chk("t1_addr1", icache_addr, 16'h3002);
      chk("t1_npc1", de_npc, 16'h3002);
      chk("t1_v", {15'd0, de_v}, 16'd1);
      icache_data = memf(m_pc); step();
      chk("t1_addr2", icache_addr, 16'h3004);
      chk("t1_npc2", de_npc, 16'h3004);

      // 2: icache not ready for three cycles
      icache_ready = 0;
      for (int i = 0; i < 3; i++) begin
         icache_data = 16'hDEAD; step();
         chk("t2_addr_hold", icache_addr, 16'h3004);
         chk("t2_v0", {15'd0, de_v}, 16'd0);
      end
      icache_ready = 1; icache_data = memf(16'h3004); step();
      chk("t2_ir", de_ir, memf(16'h3004));
      chk("t2_pc", pc, 16'h3006);

      // 3: decode stall freezes DE and PC, then the same address is refetched
      hold_ir = de_ir; hold_npc = de_npc; hold_v = de_v;
      dep_stall = 1;
      for (int i = 0; i < 2; i++) begin
         icache_data = memf(m_pc); step();
         chk("t3_ir_hold", de_ir, hold_ir);
         chk("t3_npc_hold", de_npc, hold_npc);
         chk("t3_pc_hold", pc, 16'h3006);
      end
      dep_stall = 0; icache_data = memf(m_pc); step();
      chk("t3_refetch_ir", de_ir, memf(16'h3006));
      chk("t3_pc", pc, 16'h3008);

      // 4: branch stall then redirect to target
      v_de_br_stall = 1; icache_data = memf(m_pc); step();
      chk("t4_v0", {15'd0, de_v}, 16'd0);
      chk("t4_pc_hold", pc, 16'h3008);
      mem_pcmux = 1; target_pc = 16'h4000; step();
      chk("t4_pc_tgt", pc, 16'h4000);
      chk("t4_idle", {15'd0, icache_req}, 16'd0);
      idle_inputs(); step();
      chk("t4_req_tgt", icache_addr, 16'h4000);
      chk("t4_req_on", {15'd0, icache_req}, 16'd1);

      // 5: trap redirect under mem stall leaves DE untouched; reserved pcmux is not a redirect
      hold_ir = de_ir; hold_npc = de_npc; hold_v = de_v;
      mem_pcmux = 2; trap_pc = 16'h0400; mem_stall = 1; icache_data = memf(m_pc); step();
      chk("t5_pc_trap", pc, 16'h0400);
      chk("t5_ir_hold", de_ir, hold_ir);
      chk("t5_npc_hold", de_npc, hold_npc);
      idle_inputs(); mem_pcmux = 3; target_pc = 16'h1234; trap_pc = 16'h5678; step();
      chk("t5_pcmux3_pc", pc, 16'h0400);
      chk("t5_pcmux3_req", {15'd0, icache_req}, 16'd1);

      // 6: PC wrap at FFFE, then reset in the middle of a wait
      mem_pcmux = 1; target_pc = 16'hFFFE; step();
      idle_inputs(); step();
      icache_data = memf(16'hFFFE); step();
      chk("t6_wrap_pc", pc, 16'h0000);
      chk("t6_wrap_npc", de_npc, 16'h0000);
      icache_ready = 0; step();
      reset = 1; step();
      chk("t6_rst_pc", pc, 16'h3000);
      chk("t6_rst_v", {15'd0, de_v}, 16'd0);
      chk("t6_rst_req", {15'd0, icache_req}, 16'd0);
      reset = 0;

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         reset           = ($urandom_range(0, 199) == 0);
         icache_ready    = ($urandom_range(0, 3) != 0);
         icache_data     = 16'($urandom);
         dep_stall       = ($urandom_range(0, 7) == 0);
         mem_stall       = ($urandom_range(0, 9) == 0);
         v_de_br_stall   = ($urandom_range(0, 11) == 0);
         v_agex_br_stall = ($urandom_range(0, 15) == 0);
         v_mem_br_stall  = ($urandom_range(0, 15) == 0);
         mem_pcmux       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         target_pc       = 16'($urandom) & 16'hFFFE;
         trap_pc         = 16'($urandom_range(0, 255)) << 1;
         if ($urandom_range(0, 19) == 0) target_pc = 16'hFFFE;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
